// File: rtl/uart_pkg.sv
// Shared definitions for the arbitrated UART transmitter: FSM state codes,
// parity modes, the latched per-frame configuration and the parity helper.
package uart_pkg;

    localparam int UART_DW = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef struct packed {
        logic [15:0] baud_div;
        logic        par_en;
        logic        par_odd;
    } frame_cfg_t;

    // Even parity is the plain XOR of the data bits; odd parity inverts it.
    function automatic logic parity_bit(input logic [UART_DW-1:0] data, input logic mode);
        parity_bit = (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant to the first asserted request found
// scanning upward from ptr, wrapping from NREQ-1 back to 0.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    int   idx;
    logic found;

    // Priority scan starting at ptr; the modulo keeps non-power-of-two NREQ in range.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// UART transmitter shared by NREQ byte requesters through a round-robin
// arbiter; frame timing and parity mode are frozen at accept time.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int  NREQ = 4,
    parameter int  DW   = 8,
    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int BW   = $clog2(DW)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic [15:0]        baud_div,
    input  logic               parity_en,
    input  logic               parity_odd,
    output logic               txd,
    output logic               busy,
    output logic [GW-1:0]      grant_id
);

    logic [2:0]    state_q,    state_d;
    logic [15:0]   baud_cnt_q, baud_cnt_d;
    logic [BW-1:0] bit_cnt_q,  bit_cnt_d;
    logic [DW-1:0] shift_q,    shift_d;
    logic [DW-1:0] data_q,     data_d;
    frame_cfg_t    cfg_q,      cfg_d;
    logic          txd_q,      txd_d;
    logic          busy_q,     busy_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [GW-1:0] rr_ptr_q,   rr_ptr_d;

    logic [NREQ-1:0] grant_s;
    logic            accept_s;
    logic [GW-1:0]   sel_idx_s;
    logic [GW-1:0]   next_ptr_s;
    logic [DW-1:0]   sel_data_s;
    logic            bit_end_s;

    function automatic logic [GW-1:0] onehot_idx(input logic [NREQ-1:0] oh);
        onehot_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                onehot_idx = GW'(i);
            end else begin
                onehot_idx = onehot_idx;
            end
        end
    endfunction

    rr_arb #(
        .NREQ (NREQ),
        .PW   (GW)
    ) u_rr_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant_s)
    );

    // Offer the arbiter's choice only while idle and out of reset.
    always_comb begin
        if ((state_q == ST_IDLE) && rst_n) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Decode the selected requester, its byte and the pointer that follows it.
    always_comb begin
        accept_s   = |req_ready;
        sel_idx_s  = onehot_idx(req_ready);
        sel_data_s = req_data[sel_idx_s*DW +: DW];
        bit_end_s  = (baud_cnt_q == cfg_q.baud_div);
        if (sel_idx_s == GW'(NREQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = sel_idx_s + GW'(1);
        end
    end

    // Frame sequencing; txd_d is the line level for the cycle after this one.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        cfg_d      = cfg_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (accept_s) begin
                    state_d        = ST_START;
                    txd_d          = 1'b0;
                    busy_d         = 1'b1;
                    baud_cnt_d     = 16'd0;
                    bit_cnt_d      = '0;
                    shift_d        = sel_data_s;
                    data_d         = sel_data_s;
                    cfg_d.baud_div = baud_div;
                    cfg_d.par_en   = parity_en;
                    cfg_d.par_odd  = parity_odd;
                    grant_id_d     = sel_idx_s;
                    rr_ptr_d       = next_ptr_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d    = ST_DATA;
                    baud_cnt_d = 16'd0;
                    txd_d      = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_cnt_d = 16'd0;
                    if (bit_cnt_q == BW'(DW - 1)) begin
                        if (cfg_q.par_en) begin
                            state_d = ST_PARITY;
                            txd_d   = parity_bit(data_q, cfg_q.par_odd);
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        shift_d   = {1'b0, shift_q[DW-1:1]};
                        txd_d     = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d    = ST_STOP;
                    baud_cnt_d = 16'd0;
                    txd_d      = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    state_d    = ST_IDLE;
                    baud_cnt_d = 16'd0;
                    txd_d      = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = 16'd0;
                txd_d      = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any partial frame and parks the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            cfg_q      <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            cfg_q      <= cfg_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign txd      = txd_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: random frames compared cycle by cycle
// against a frame/arbitration model built from the serial-line rules.
module tb_uart_tx_arb;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic               clk        = 1'b0;
    logic               rst_n      = 1'b1;
    logic [NREQ-1:0]    req_valid  = '0;
    logic [NREQ*DW-1:0] req_data   = '0;
    logic [NREQ-1:0]    req_ready;
    logic [15:0]        baud_div   = 16'd0;
    logic               parity_en  = 1'b0;
    logic               parity_odd = 1'b0;
    logic               txd;
    logic               busy;
    logic [1:0]         grant_id;

    int n_vec = 0;
    int n_err = 0;
    int rr_m  = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx_arb #(.NREQ(NREQ), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .txd        (txd),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Line level for every cycle of a frame, starting with the cycle after accept.
    task automatic model_frame(input logic [7:0] d, input bit pen, input bit podd, input int div);
        bit bits[$];
        int ones;
        exp_q = {};
        bits.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pen) bits.push_back(podd ? (ones % 2 == 0) : (ones % 2 == 1));
        bits.push_back(1'b1);
        foreach (bits[b]) for (int r = 0; r <= div; r++) exp_q.push_back(bits[b]);
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) if (v[(rr_m + k) % NREQ]) return (rr_m + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int g);
        logic [NREQ-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        req_valid = '1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b want 1", txd); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        req_valid = '0;
        rst_n = 1'b1;
        rr_m = 0;
        tick();
    endtask

    task automatic test_round_robin();
        int div, g;
        bit pen, podd;
        logic [7:0] rx;
        div = $urandom_range(0, 2);
        pen = 1'($urandom_range(0, 1));
        podd = 1'($urandom_range(0, 1));
        baud_div = 16'(div); parity_en = pen; parity_odd = podd;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'hA0 + 8'(i);
        req_valid = '1;
        for (int f = 0; f < 5; f++) begin
            #1;
            g = model_grant(req_valid);
            n_vec++; if (req_ready !== oh(g)) begin n_err++; $display("FAIL rr_ready frame %0d: got %b want %b", f, req_ready, oh(g)); end
            rr_m = (g + 1) % NREQ;
            model_frame(8'hA0 + 8'(g), pen, podd, div);
            rx = '0;
            foreach (exp_q[c]) begin
                tick();
                n_vec++;
                if (txd !== exp_q[c] || busy !== 1'b1) begin
                    n_err++; $display("FAIL rr_line frame %0d cyc %0d: txd=%b busy=%b want txd=%b busy=1", f, c, txd, busy, exp_q[c]);
                end
                if (c >= div + 1 && c < 9 * (div + 1) && c % (div + 1) == 0) rx[c / (div + 1) - 1] = txd;
            end
            n_vec++;
            if (grant_id !== 2'(g) || rx !== 8'hA0 + 8'(grant_id)) begin
                n_err++; $display("FAIL rr_grant frame %0d: grant_id=%0d byte=%h want grant_id=%0d byte=%h", f, grant_id, rx, g, 8'hA0 + 8'(g));
            end
            tick();
            n_vec++; if (busy !== 1'b0 || txd !== 1'b1) begin n_err++; $display("FAIL rr_idle frame %0d: busy=%b txd=%b want 0/1", f, busy, txd); end
        end
        req_valid = '0;
    endtask

    task automatic test_spec_frame();
        int nb;
        baud_div = 16'd3; parity_en = 1'b1; parity_odd = 1'b0;
        req_data[7:0] = 8'h55;
        req_valid = 4'b0001;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL spec_ready: got %b want 0001", req_ready); end
        rr_m = 1;
        model_frame(8'h55, 1'b1, 1'b0, 3);
        nb = 0;
        foreach (exp_q[c]) begin
            tick();
            if (c == 0) req_valid = '0;
            n_vec++; if (txd !== exp_q[c]) begin n_err++; $display("FAIL spec_txd cyc %0d: got %b want %b", c, txd, exp_q[c]); end
            if (busy === 1'b1) nb++;
        end
        n_vec++; if (nb != 44 || grant_id !== 2'd0) begin n_err++; $display("FAIL spec_busy_len: busy cycles %0d grant %0d want 44 / 0", nb, grant_id); end
        tick();
        n_vec++; if (busy !== 1'b0 || txd !== 1'b1) begin n_err++; $display("FAIL spec_idle: busy=%b txd=%b want 0/1", busy, txd); end
    endtask

    task automatic test_random_frames();
        int div, g, nb;
        bit pen, podd;
        logic [NREQ-1:0] m;
        logic [7:0] d;
        for (int t = 0; t < 8; t++) begin
            div = $urandom_range(0, 3);
            pen = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'($urandom);
            if (t == 0) begin pen = 1'b1; podd = 1'b1; end
            if (t == 1) pen = 1'b0;
            if (t < 2) req_data = {NREQ{8'h01}};
            baud_div = 16'(div); parity_en = pen; parity_odd = podd;
            // first offer a mask, then change it before the edge: arbitration must follow
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req_valid = m;
            #1;
            g = model_grant(m);
            n_vec++; if (req_ready !== oh(g)) begin n_err++; $display("FAIL rand_ready1 t%0d: got %b want %b", t, req_ready, oh(g)); end
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req_valid = m;
            #1;
            g = model_grant(m);
            n_vec++; if (req_ready !== oh(g)) begin n_err++; $display("FAIL rand_ready2 t%0d: got %b want %b", t, req_ready, oh(g)); end
            rr_m = (g + 1) % NREQ;
            d = req_data[g*DW +: DW];
            model_frame(d, pen, podd, div);
            nb = 0;
            foreach (exp_q[c]) begin
                tick();
                if (c == 0) begin req_valid = '0; parity_en = ~pen; parity_odd = ~podd; end
                n_vec++;
                if (txd !== exp_q[c] || busy !== 1'b1) begin
                    n_err++; $display("FAIL rand_line t%0d cyc %0d: txd=%b busy=%b want txd=%b busy=1", t, c, txd, busy, exp_q[c]);
                end
                if (t == 0 && c == 9 * (div + 1)) begin
                    n_vec++; if (txd !== 1'b0) begin n_err++; $display("FAIL odd_parity_01: got %b want 0", txd); end
                end
                if (busy === 1'b1) nb++;
            end
            n_vec++;
            if (nb != (pen ? 11 : 10) * (div + 1) || grant_id !== 2'(g)) begin
                n_err++; $display("FAIL rand_len t%0d: busy cycles %0d grant %0d want %0d / %0d", t, nb, grant_id, (pen ? 11 : 10) * (div + 1), g);
            end
            tick();
            n_vec++; if (busy !== 1'b0 || txd !== 1'b1) begin n_err++; $display("FAIL rand_idle t%0d: busy=%b txd=%b want 0/1", t, busy, txd); end
        end
    endtask

    task automatic test_fast_bits();
        int g, nlow, nhigh;
        baud_div = 16'd0; parity_en = 1'b0; parity_odd = 1'b0;
        req_data = {NREQ{8'hFF}};
        req_valid = '1;
        #1;
        g = model_grant(req_valid);
        n_vec++; if (req_ready !== oh(g)) begin n_err++; $display("FAIL fast_ready: got %b want %b", req_ready, oh(g)); end
        rr_m = (g + 1) % NREQ;
        model_frame(8'hFF, 1'b0, 1'b0, 0);
        nlow = 0; nhigh = 0;
        foreach (exp_q[c]) begin
            tick();
            n_vec++; if (txd !== exp_q[c]) begin n_err++; $display("FAIL fast_txd cyc %0d: got %b want %b", c, txd, exp_q[c]); end
            if (txd === 1'b1) nhigh++; else nlow++;
        end
        n_vec++; if (nlow != 1 || nhigh != 9) begin n_err++; $display("FAIL fast_bits: low %0d high %0d want 1 / 9", nlow, nhigh); end
        tick();
        n_vec++; if (busy !== 1'b0 || txd !== 1'b1) begin n_err++; $display("FAIL fast_gap: busy=%b txd=%b want 0/1", busy, txd); end
        #1;
        g = model_grant(req_valid);
        n_vec++; if (req_ready !== oh(g)) begin n_err++; $display("FAIL fast_ready2: got %b want %b", req_ready, oh(g)); end
        rr_m = (g + 1) % NREQ;
        tick();
        n_vec++;
        if (txd !== 1'b0 || busy !== 1'b1 || grant_id !== 2'(g)) begin
            n_err++; $display("FAIL fast_next: txd=%b busy=%b grant=%0d want 0/1/%0d", txd, busy, grant_id, g);
        end
        req_valid = '0;
        for (int k = 0; k < 40 && busy !== 1'b0; k++) tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fast_timeout: busy=%b want 0", busy); end
    endtask

    task automatic test_baud_change();
        logic [7:0] d1, d2;
        d1 = 8'($urandom); d2 = 8'($urandom);
        baud_div = 16'd3; parity_en = 1'b0;
        req_data[15:8] = d1;
        req_valid = 4'b0010;
        #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL baud_ready1: got %b want 0010", req_ready); end
        rr_m = 2;
        model_frame(d1, 1'b0, 1'b0, 3);
        foreach (exp_q[c]) begin
            tick();
            if (c == 0) req_data[15:8] = d2;
            if (c == 10) baud_div = 16'd7;
            n_vec++; if (txd !== exp_q[c]) begin n_err++; $display("FAIL baud_old cyc %0d: got %b want %b", c, txd, exp_q[c]); end
        end
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL baud_idle: busy=%b want 0", busy); end
        #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL baud_ready2: got %b want 0010", req_ready); end
        model_frame(d2, 1'b0, 1'b0, 7);
        foreach (exp_q[c]) begin
            tick();
            if (c == 0) req_valid = '0;
            n_vec++; if (txd !== exp_q[c] || busy !== 1'b1) begin n_err++; $display("FAIL baud_new cyc %0d: txd=%b busy=%b want %b/1", c, txd, busy, exp_q[c]); end
        end
        tick();
        n_vec++; if (busy !== 1'b0 || txd !== 1'b1) begin n_err++; $display("FAIL baud_idle2: busy=%b txd=%b want 0/1", busy, txd); end
    endtask

    task automatic test_reset_mid();
        baud_div = 16'd3; parity_en = 1'($urandom_range(0, 1));
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'($urandom);
        req_valid = 4'b0100;
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL mid_ready: got %b want 0100", req_ready); end
        tick();
        repeat (17) tick();
        n_vec++; if (busy !== 1'b1 || grant_id !== 2'd2) begin n_err++; $display("FAIL mid_busy: busy=%b grant=%0d want 1/2", busy, grant_id); end
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (txd !== 1'b1 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            n_err++; $display("FAIL mid_reset: txd=%b busy=%b ready=%b want 1/0/0000", txd, busy, req_ready);
        end
        tick(); tick();
        rst_n = 1'b1;
        rr_m = 0;
        #1;
        n_vec++; if (req_ready !== oh(model_grant(req_valid))) begin n_err++; $display("FAIL post_reset_ready: got %b want 0001", req_ready); end
        tick();
        n_vec++;
        if (grant_id !== 2'd0 || txd !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL post_reset_grant: grant=%0d txd=%b busy=%b want 0/0/1", grant_id, txd, busy);
        end
        req_valid = '0;
        rr_m = 1;
        for (int k = 0; k < 100 && busy !== 1'b0; k++) tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_timeout: busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_spec_frame();
        test_random_frames();
        test_fast_bits();
        test_baud_change();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached after %0d vectors", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4, number of byte requesters sharing the transmitter (2..8).
REQ-002 Parameter DW, default 8, data bits per frame (fixed 8 in this release).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NREQ  per-requester byte available.
REQ-006 req_data  input  NREQ*DW  packed bytes; requester i at bits [i*DW +: DW].
REQ-007 req_ready  output  NREQ  one-hot accept strobe; byte i taken when req_valid[i] & req_ready[i].
REQ-008 baud_div  input  16  bit period minus one, in clk cycles.
REQ-009 parity_en  input  1  1 = append parity bit.
REQ-010 parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-011 txd  output  1  serial line, idle high.
REQ-012 busy  output  1  high from the cycle after accept through the last stop-bit cycle.
REQ-013 grant_id  output  $clog2(NREQ)  index of the requester owning the current frame; holds its last value when idle.

Function
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-015 In IDLE with any req_valid set, req_ready SHALL be asserted combinationally for exactly one requester, chosen round-robin starting at rr_ptr.
REQ-016 On accept, the block SHALL latch data, grant_id, parity_en and parity_odd, and set rr_ptr to (grant+1) mod NREQ.
REQ-017 After accept, the FSM SHALL enter START, and txd SHALL go low on the next cycle.
REQ-018 Each bit SHALL last exactly baud_div+1 cycles; baud_div is sampled at accept, so changes mid-frame SHALL have no effect.
REQ-019 baud_div=0 SHALL give 1-cycle bits; 0xFFFF SHALL give 65536-cycle bits.
REQ-020 DATA SHALL shift out bits LSB first, 8 bits.
REQ-021 PARITY SHALL be entered only if parity_en was latched; its bit SHALL be the XOR of the data bits, inverted when parity_odd is set; otherwise DATA goes directly to STOP.
REQ-022 STOP SHALL drive txd high for one bit period and then return to IDLE.
REQ-023 A new frame SHALL NOT be accepted before the FSM is back in IDLE, giving a minimum inter-frame gap of 1 idle cycle.
REQ-024 req_ready SHALL be all zeros outside IDLE.
REQ-025 A requester dropping req_valid in IDLE before accept SHALL lose nothing; arbitration SHALL re-evaluate every cycle.
REQ-026 When NREQ is not a power of two, rr_ptr SHALL wrap from NREQ-1 to 0.

Reset
REQ-027 Reset SHALL set the state to IDLE, txd=1, busy=0, req_ready=0, grant_id=0, rr_ptr=0, and clear the baud counter, bit counter and shift register.
REQ-028 Reset asserted mid-frame SHALL force txd high immediately; the partial frame SHALL be dropped and is not retransmitted.

Structure
REQ-029 State encoding and the parity-mode constants SHALL live in the shared package uart_pkg.
REQ-030 The round-robin grant logic SHALL be a sub-module, rr_arb (inputs req and ptr, output one-hot grant).
REQ-031 The baud counter, bit counter and FSM SHALL stay in uart_tx_arb; target size is 120-400 RTL lines.

Verification
REQ-032 baud_div=3, parity_en=1, parity_odd=0, req0 sends 0x55 -> txd = 0,1,0,1,0,1,0,1,0,0(parity),1, each bit 4 cycles; busy high for 44 cycles.
REQ-033 All 4 valid continuously, each sending 0xA0+i -> accept order 0,1,2,3,0; each frame's grant_id matches its byte.
REQ-034 parity_odd=1, data 0x01 -> parity bit 0; parity_en=0, data 0x01 -> frame is 10 bits, no parity bit.
REQ-035 baud_div=0, data 0xFF, parity off -> txd low 1 cycle, high 9 cycles, then the next accept possible 1 cycle later.
REQ-036 rst_n low during DATA bit 3 -> txd=1 and busy=0 immediately; after release, rr_ptr=0 and req0 is granted first.
REQ-037 baud_div changed from 3 to 7 mid-frame -> the current frame keeps 4-cycle bits and the next frame uses 8-cycle bits.
